// File: rtl/sseg_ctrl_pkg.sv
// rtl/sseg_ctrl_pkg.sv - shared types and constants for the segment-chase controller
package sseg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } anim_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_BLANK  = 4'hF;

  // Anode pattern with only digit k pulled low.
  function automatic logic [NUM_DIGITS-1:0] an_select(input logic [1:0] k);
    an_select = ~(4'b0001 << k);
  endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// rtl/sseg_tick_gen.sv - free-running divider producing a 1-cycle tick every DIV enabled cycles
module sseg_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // The counter holds while disabled, so a paused divider resumes mid-period.
  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/sseg_anim_controller.sv
// rtl/sseg_anim_controller.sv - step sequencer and digit scanner for the 4-digit chase animation
// Optional duty-cycle dimming is built when SSEG_DIMMING_EN is defined.
module sseg_anim_controller
  import sseg_ctrl_pkg::*;
#(
  parameter int STEP_DIV  = 25_000_000,
  parameter int SCAN_DIV  = 100_000,
  parameter int NUM_STEPS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        dir,
  input  logic [1:0]  bright,
  input  logic [27:0] ssegValues,
  output logic [2:0]  step,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        lap_done
);

  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  anim_state_t state, state_next;
  logic        step_tick;
  logic        scan_tick;
  logic        at_wrap;
  logic [1:0]  scan_k;
  logic [SEG_W-1:0] digit_seg;
  logic        lit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // stop is checked first everywhere so it wins over a simultaneous start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!stop && start) state_next = RUN;
      RUN:     if (stop) state_next = PAUSE;
      PAUSE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  sseg_tick_gen #(.DIV(STEP_DIV)) u_step_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == RUN),
    .clr   (state == IDLE),
    .tick  (step_tick)
  );

  sseg_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != IDLE),
    .clr   (state == IDLE),
    .tick  (scan_tick)
  );

  always_comb begin
    at_wrap = dir ? (step == 3'd0) : (step == LAST_STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step     <= 3'd0;
      lap_done <= 1'b0;
    end else begin
      lap_done <= step_tick && at_wrap;
      if (state_next == IDLE) begin
        step <= 3'd0;
      end else if (step_tick) begin
        if (dir) begin
          step <= (step == 3'd0) ? LAST_STEP : step - 3'd1;
        end else begin
          step <= (step == LAST_STEP) ? 3'd0 : step + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_k <= 2'd0;
    end else if (state == IDLE) begin
      scan_k <= 2'd0;
    end else if (scan_tick) begin
      scan_k <= scan_k + 2'd1;
    end
  end

  assign digit_seg = ssegValues[SEG_W*scan_k +: SEG_W];

`ifdef SSEG_DIMMING_EN
  localparam int SUB_DIV = SCAN_DIV / 4;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] slot_pos;
  logic [1:0]    bright_q;
  logic [1:0]    sub_idx;

  // slot_pos tracks the scan divider; bright is latched as each slot begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_pos <= '0;
      bright_q <= 2'd0;
    end else if (state == IDLE || scan_tick) begin
      slot_pos <= '0;
      bright_q <= bright;
    end else begin
      slot_pos <= slot_pos + 1'b1;
    end
  end

  assign sub_idx = 2'(32'(slot_pos) / SUB_DIV);
  assign lit     = (sub_idx <= bright_q);
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign lit           = 1'b1;
`endif

  // All anodes go dark on the scan-tick cycle so the old segments never flash on the new digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= AN_BLANK;
      seg <= SEG_BLANK;
    end else if (state == IDLE || !lit) begin
      an  <= AN_BLANK;
      seg <= SEG_BLANK;
    end else begin
      an  <= scan_tick ? AN_BLANK : an_select(scan_k);
      seg <= digit_seg;
    end
  end

endmodule

// File: tb/tb_sseg_anim_controller.sv
// tb/tb_sseg_anim_controller.sv - self-checking bench for sseg_anim_controller
module tb_sseg_anim_controller;

  localparam int STEP_DIV  = 8;
  localparam int SCAN_DIV  = 4;
  localparam int NUM_STEPS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, dir;
  logic [1:0]  bright;
  logic [27:0] sseg_values;
  logic [2:0]  step_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        lap_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sseg_anim_controller #(
    .STEP_DIV  (STEP_DIV),
    .SCAN_DIV  (SCAN_DIV),
    .NUM_STEPS (NUM_STEPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .bright     (bright),
    .ssegValues (sseg_values),
    .step       (step_o),
    .an         (an_o),
    .seg        (seg_o),
    .lap_done   (lap_o)
  );

  // Stand-in pattern decoder: two lit segments per step, spread across digits.
  function automatic logic [27:0] dec(input int s);
    logic [27:0] p;
    p = '1;
    p[(s % 4) * 7 + (s % 7)] = 1'b0;
    p[((s + 1) % 4) * 7 + ((s + 3) % 7)] = 1'b0;
    return p;
  endfunction

  assign sseg_values = dec(int'(step_o));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=pause; counters are cycles spent running / scanning.
  int   m_mode, m_step, m_run, m_scan, m_bright, m_pos, m_k;
  bit   m_valid = 0;
  bit   m_tick;
  logic [27:0] m_pat;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_lap;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_step = 0; m_run = 0; m_scan = 0; m_bright = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_lap = 1'b0;
      m_valid = 1;
    end else begin
      m_pos = m_scan % SCAN_DIV;
      m_k   = (m_scan / SCAN_DIV) % 4;
      m_pat = dec(m_step);
      if (m_mode == 0) begin
        e_an = 4'hF; e_seg = 7'h7F;
      end else begin
        e_an  = (m_pos == SCAN_DIV - 1) ? 4'hF : ~(4'b0001 << m_k);
        e_seg = m_pat[m_k * 7 +: 7];
`ifdef SSEG_DIMMING_EN
        if (m_pos / (SCAN_DIV / 4) > m_bright) begin
          e_an = 4'hF; e_seg = 7'h7F;
        end
`endif
      end
      m_tick = (m_mode == 1) && (m_run == STEP_DIV - 1);
      e_lap  = m_tick && (dir ? (m_step == 0) : (m_step == NUM_STEPS - 1));
      if (m_tick) m_step = dir ? (m_step + NUM_STEPS - 1) % NUM_STEPS : (m_step + 1) % NUM_STEPS;
      if (m_mode == 1) m_run = (m_run + 1) % STEP_DIV;
      if (m_mode == 0 || m_pos == SCAN_DIV - 1) m_bright = int'(bright);
      if (m_mode != 0) m_scan++;
      if (stop) begin
        if (m_mode == 1) m_mode = 2;
        else if (m_mode == 2) m_mode = 0;
      end else if (start && m_mode != 1) begin
        m_mode = 1;
      end
      if (m_mode == 0) begin
        m_step = 0; m_run = 0; m_scan = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_step", 32'(step_o), 32'(m_step));
      check("model_an", 32'(an_o), 32'(e_an));
      check("model_seg", 32'(seg_o), 32'(e_seg));
      check("model_lap", 32'(lap_o), 32'(e_lap));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  int chg_at[$];
  int chg_val[$];
  int laps, lap_at, prev, rot_bad, frozen_bad, lit_cnt, trans;
  logic [3:0] last_an;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; bright = 2'd3;
    cyc(3);
    rst_n = 1'b1;
    check("reset_an", 32'(an_o), 32'hF);
    check("reset_seg", 32'(seg_o), 32'h7F);
    check("reset_step", 32'(step_o), 32'd0);

    // 1: idle stays blank, no laps
    laps = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lap_o === 1'b1) laps++;
    end
    check("idle_laps", 32'(laps), 32'd0);
    check("idle_an", 32'(an_o), 32'hF);

    // 2: forward lap
    dir = 1'b0;
    pulse_start();
    chg_at.delete(); chg_val.delete(); laps = 0; lap_at = -1; prev = int'(step_o);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (int'(step_o) != prev) begin
        chg_at.push_back(i); chg_val.push_back(int'(step_o)); prev = int'(step_o);
      end
      if (lap_o === 1'b1) begin laps++; lap_at = i; end
    end
    check("fwd_nchg", 32'(chg_val.size()), 32'd8);
    if (chg_val.size() == 8) begin
      check("fwd_first_at", 32'(chg_at[0]), 32'd7);
      for (int i = 0; i < 8; i++) check("fwd_val", 32'(chg_val[i]), 32'((i + 1) % 8));
      for (int i = 1; i < 8; i++) check("fwd_gap", 32'(chg_at[i] - chg_at[i-1]), 32'd8);
      check("fwd_lap_at", 32'(lap_at), 32'(chg_at[7]));
    end
    check("fwd_laps", 32'(laps), 32'd1);
    pulse_stop();
    pulse_stop();
    cyc(2);
    check("fwd_idle_step", 32'(step_o), 32'd0);
    check("fwd_idle_an", 32'(an_o), 32'hF);

    // 3: reverse, then dir flip mid-step
    dir = 1'b1;
    pulse_start();
    chg_at.delete(); chg_val.delete(); laps = 0; prev = int'(step_o);
    for (int i = 0; i < 40 && chg_val.size() < 2; i++) begin
      @(negedge clk);
      if (int'(step_o) != prev) begin
        chg_at.push_back(i); chg_val.push_back(int'(step_o)); prev = int'(step_o);
      end
      if (lap_o === 1'b1) laps++;
    end
    check("rev_nchg", 32'(chg_val.size()), 32'd2);
    if (chg_val.size() == 2) begin
      check("rev_v0", 32'(chg_val[0]), 32'd7);
      check("rev_v1", 32'(chg_val[1]), 32'd6);
    end
    check("rev_laps", 32'(laps), 32'd1);
    cyc(3);
    dir = 1'b0;
    begin
      int gap;
      gap = 3;
      for (int i = 0; i < 20 && int'(step_o) == prev; i++) begin
        @(negedge clk);
        gap++;
      end
      check("flip_val", 32'(step_o), 32'd7);
      check("flip_gap", 32'(gap), 32'd8);
    end
    pulse_stop();
    pulse_stop();
    cyc(2);

    // 4: pause at step 3 keeps scanning
    pulse_start();
    for (int i = 0; i < 60 && step_o != 3'd3; i++) @(negedge clk);
    check("pause_reach3", 32'(step_o), 32'd3);
    pulse_stop();
    rot_bad = 0; frozen_bad = 0; trans = 0; last_an = 4'hF;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (step_o != 3'd3) frozen_bad++;
      if (an_o != 4'hF) begin
        if (last_an != 4'hF && an_o != last_an) begin
          trans++;
          if (an_o != {last_an[2:0], last_an[3]}) rot_bad++;
        end
        last_an = an_o;
      end
    end
    check("pause_frozen", 32'(frozen_bad), 32'd0);
    check("pause_rot", 32'(rot_bad), 32'd0);
    check("pause_trans", 32'(trans >= 4), 32'd1);
    pulse_stop();
    cyc(2);
    check("pause_idle_step", 32'(step_o), 32'd0);
    check("pause_idle_an", 32'(an_o), 32'hF);

    // 5: simultaneous start/stop
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    cyc(20);
    check("both_idle_an", 32'(an_o), 32'hF);
    check("both_idle_step", 32'(step_o), 32'd0);
    pulse_start();
    cyc(10);
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    prev = int'(step_o); lit_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an_o != 4'hF) lit_cnt++;
    end
    check("both_run_frozen", 32'(step_o), 32'(prev));
    check("both_run_lit", 32'(lit_cnt > 0), 32'd1);

    // reset mid-frame
    pulse_start();
    cyc(5);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_an", 32'(an_o), 32'hF);
    check("rst_seg", 32'(seg_o), 32'h7F);
    check("rst_step", 32'(step_o), 32'd0);
    check("rst_lap", 32'(lap_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc(5);
    check("rst_idle_an", 32'(an_o), 32'hF);

`ifdef SSEG_DIMMING_EN
    bright = 2'd0;
    cyc(2);
    pulse_start();
    cyc(2);
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an_o != 4'hF) lit_cnt++;
    end
    check("dim_lit", 32'(lit_cnt), 32'd4);
`endif

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
